// File: rtl/fsm_pattern_pkg.sv
// Shared constants for the serial pattern generator: FSM state encoding,
// default frame length and the frame recognised by the downstream detector.
package fsm_pattern_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int PAT_LEN_DEFAULT = 7;

  localparam logic [PAT_LEN_DEFAULT-1:0] DEFAULT_PATTERN = 7'b1010111;

endpackage

// File: rtl/bit_tick_div.sv
// Bit-period counter: counts 0..div-1 while enabled (clear low) and flags the
// last cycle of each period on tick. A div of 0 behaves like 1.
module bit_tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (div == '0) || (r_cnt == (div - DIV_W'(1)));
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/fsm_pattern_gen.sv
// Serial frame generator: sends a latched PAT_LEN-bit pattern MSB first, each bit
// held for N cycles, repeated R times with N-cycle zero gaps, then a done pulse.
module fsm_pattern_gen
  import fsm_pattern_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEFAULT,
  parameter int DIV_W   = 8,
  parameter int RPT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic [RPT_W-1:0]   repeat_cnt,
  input  logic [DIV_W-1:0]   bit_div,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         o_dbg_state
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_LEN - 1);

  logic [1:0]         r_state;
  logic [PAT_LEN-1:0] r_pat;
  logic [DIV_W-1:0]   r_div;
  logic [RPT_W-1:0]   r_frames;
  logic [IDX_W-1:0]   r_idx;
  logic               r_out;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_tick;
  logic               w_clear;
  logic [DIV_W-1:0]   w_div_eff;
  logic [RPT_W-1:0]   w_frames_init;

  // r_frames holds the number of frames still to send after the current one.
  assign w_div_eff     = (bit_div == '0) ? DIV_W'(1) : bit_div;
  assign w_frames_init = (repeat_cnt == '0) ? '0 : (repeat_cnt - RPT_W'(1));
  assign w_clear       = !((r_state == ST_SHIFT) || (r_state == ST_GAP));

  bit_tick_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .div   (r_div),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pat       <= '0;
      r_div       <= '0;
      r_frames    <= '0;
      r_idx       <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= ST_SHIFT;
            r_pat       <= pattern_in;
            r_div       <= w_div_eff;
            r_frames    <= w_frames_init;
            r_idx       <= IDX_MSB;
            r_out       <= pattern_in[PAT_LEN-1];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (r_idx == '0) begin
              r_out       <= 1'b0;
              r_out_valid <= 1'b0;
              if (r_frames != '0) begin
                r_state  <= ST_GAP;
                r_frames <= r_frames - RPT_W'(1);
              end else begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_idx <= r_idx - IDX_W'(1);
              r_out <= r_pat[r_idx - IDX_W'(1)];
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_state     <= ST_SHIFT;
            r_idx       <= IDX_MSB;
            r_out       <= r_pat[PAT_LEN-1];
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fsm_pattern_gen.sv
// Bench for fsm_pattern_gen: per-cycle expected {out,out_valid,busy,done}
// built from frame/bit/period arithmetic and compared against the DUT.
module tb_fsm_pattern_gen;
  import fsm_pattern_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] pattern_in;
  logic [3:0] repeat_cnt;
  logic [7:0] bit_div;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [1:0] o_dbg_state;

  int n_checks;
  int n_pass;
  logic [3:0] exp_q[$];
  int hit_q[$];

  fsm_pattern_gen #(
    .PAT_LEN (7),
    .DIV_W   (8),
    .RPT_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pattern_in  (pattern_in),
    .repeat_cnt  (repeat_cnt),
    .bit_div     (bit_div),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs starting at the cycle after the start edge.
  task automatic build_model(input logic [6:0] pat, input logic [3:0] rpt, input logic [7:0] div);
    int r_eff;
    int n_eff;
    r_eff = (rpt == 4'd0) ? 1 : int'(rpt);
    n_eff = (div == 8'd0) ? 1 : int'(div);
    for (int f = 0; f < r_eff; f++) begin
      for (int b = 6; b >= 0; b--) begin
        for (int k = 0; k < n_eff; k++) exp_q.push_back({pat[b], 3'b110});
      end
      if (f < r_eff - 1) begin
        for (int k = 0; k < n_eff; k++) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0001);
    repeat (2) exp_q.push_back(4'b0000);
  endtask

  task automatic run_xfer(input string name, input logic [6:0] pat, input logic [3:0] rpt,
                          input logic [7:0] div, input int lock_c, input int rst_c,
                          input bit scramble);
    logic [3:0] got;
    logic [3:0] exp;
    logic [6:0] hist;
    int n;
    int dones;
    int exp_dones;
    hist = '0;
    dones = 0;
    exp_dones = (rst_c > 0) ? 0 : 1;
    exp_q.delete();
    hit_q.delete();
    build_model(pat, rpt, div);
    if (rst_c > 0) begin
      while (exp_q.size() > rst_c) void'(exp_q.pop_back());
      repeat (4) exp_q.push_back(4'b0000);
    end
    n = exp_q.size();
    @(negedge clk);
    pattern_in = pat;
    repeat_cnt = rpt;
    bit_div    = div;
    start      = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= n; c++) begin
      got = {out, out_valid, busy, done};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL %s cycle %0d: got {out,valid,busy,done}=%b expected %b", name, c, got, exp);
      else n_pass++;
      if (done === 1'b1) dones++;
      hist = {hist[5:0], out};
      if (hist == DEFAULT_PATTERN) hit_q.push_back(c);
      start = 1'b0;
      reset = 1'b0;
      if (c == lock_c) begin
        start      = 1'b1;
        pattern_in = ~pat;
      end
      if (c == rst_c) reset = 1'b1;
      if (scramble) begin
        pattern_in = 7'($urandom);
        repeat_cnt = 4'($urandom);
        bit_div    = 8'($urandom);
        if ((exp[1] || exp[0]) && ($urandom_range(0, 3) == 0)) start = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    n_checks++;
    if (dones !== exp_dones) $display("FAIL %s done_count: got %0d expected %0d", name, dones, exp_dones);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out, out_valid, busy, done, o_dbg_state} !== {4'b0000, ST_IDLE})
      $display("FAIL reset_outputs: got %b/%b expected 0000/%b", {out, out_valid, busy, done}, o_dbg_state, ST_IDLE);
    else n_pass++;
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out, out_valid, busy, done, o_dbg_state} !== {4'b0000, ST_IDLE})
      $display("FAIL reset_idle_hold: got %b/%b expected 0000/%b", {out, out_valid, busy, done}, o_dbg_state, ST_IDLE);
    else n_pass++;
  endtask

  task automatic test_default_frame();
    run_xfer("default_frame", DEFAULT_PATTERN, 4'd1, 8'd1, 0, 0, 1'b0);
  endtask

  task automatic test_slow_bits();
    run_xfer("slow_bits", DEFAULT_PATTERN, 4'd1, 8'd3, 0, 0, 1'b0);
  endtask

  task automatic test_repeat_loopback();
    run_xfer("repeat_loopback", DEFAULT_PATTERN, 4'd2, 8'd1, 0, 0, 1'b0);
    n_checks++;
    if (hit_q.size() != 2 || hit_q[0] != 7 || hit_q[1] != 15)
      $display("FAIL detector_hits: got %0d hits (first %0d) expected 2 hits at 7 and 15",
               hit_q.size(), (hit_q.size() > 0) ? hit_q[0] : -1);
    else n_pass++;
  endtask

  task automatic test_busy_lockout();
    run_xfer("busy_lockout", DEFAULT_PATTERN, 4'd1, 8'd1, 4, 0, 1'b0);
  endtask

  task automatic test_reset_abort();
    run_xfer("reset_abort", DEFAULT_PATTERN, 4'd1, 8'd1, 0, 3, 1'b0);
    run_xfer("after_abort", 7'b1100101, 4'd1, 8'd2, 0, 0, 1'b0);
  endtask

  task automatic test_zero_inputs();
    run_xfer("zero_inputs", DEFAULT_PATTERN, 4'd0, 8'd0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_xfer("random", 7'($urandom), 4'($urandom_range(0, 3)), 8'($urandom_range(0, 4)), 0, 0, 1'b1);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    pattern_in = '0;
    repeat_cnt = '0;
    bit_div    = '0;
    test_reset();
    test_default_frame();
    test_slow_bits();
    test_repeat_loopback();
    test_busy_lockout();
    test_reset_abort();
    test_zero_inputs();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
